// File: rtl/rand_req_sched_pkg.sv
// Shared types, widths and request-decode helpers for the TRNG host request scheduler.
package rand_req_sched_pkg;

  localparam int OUTPUT_WIDTH   = 16;
  localparam int TIMEOUT_CYCLES = 512;

  typedef enum logic [2:0] {
    RDSEED_16 = 3'd0,
    RDSEED_32 = 3'd1,
    RDSEED_64 = 3'd2,
    RDRAND_16 = 3'd3,
    RDRAND_32 = 3'd4,
    RDRAND_64 = 3'd5
  } rand_req_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_TICK = 2'd2,
    PRESENT   = 2'd3
  } sched_state_e;

  // Unknown or unused encodings fall to default, so an X type is reported as bad.
  function automatic logic req_valid(rand_req_t t);
    case (t)
      RDSEED_16, RDSEED_32, RDSEED_64,
      RDRAND_16, RDRAND_32, RDRAND_64: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] req_words(rand_req_t t);
    case (t)
      RDSEED_16, RDRAND_16: return 3'd1;
      RDSEED_32, RDRAND_32: return 3'd2;
      RDSEED_64, RDRAND_64: return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic req_is_seed(rand_req_t t);
    case (t)
      RDSEED_16, RDSEED_32, RDSEED_64: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rand_req_sched_if.sv
// Request, source and host-facing signal bundle of the request scheduler.
interface rand_req_sched_if;
  import rand_req_sched_pkg::*;

  // Source handshake: a word moves on any ic_clk edge where *_valid and *_ready
  // are both high; valid may rise or fall freely, ready never waits on valid.
  logic                    rand_req;
  rand_req_t               rand_req_type;
  logic [OUTPUT_WIDTH-1:0] seed_data;
  logic                    seed_valid;
  logic                    seed_ready;
  logic [OUTPUT_WIDTH-1:0] drbg_data;
  logic                    drbg_valid;
  logic                    drbg_ready;
  logic [OUTPUT_WIDTH-1:0] rand_byte;
  logic                    rand_valid;
  logic                    busy;
  logic                    req_err;

  modport slave (
    input  rand_req, rand_req_type, seed_data, seed_valid, drbg_data, drbg_valid,
    output seed_ready, drbg_ready, rand_byte, rand_valid, busy, req_err
  );

  modport master (
    output rand_req, rand_req_type, seed_data, seed_valid, drbg_data, drbg_valid,
    input  seed_ready, drbg_ready, rand_byte, rand_valid, busy, req_err
  );

endinterface

// File: rtl/rand_req_sched_stage.sv
// One-entry holding register between the selected source and the host output register.
module rand_req_sched_stage
  import rand_req_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [OUTPUT_WIDTH-1:0] din,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    full
);

  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      data_d = din;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/rand_req_sched.sv
// TRNG host request scheduler: fetches 1/2/4 words from seed or DRBG source and paces them
// onto rand_byte one per slow_tick. Optional fetch timeout: define REQ_TIMEOUT_EN.
module rand_req_sched
  import rand_req_sched_pkg::*;
(
  input  logic             ic_clk,
  input  logic             rst_n,
  input  logic             debug,
  input  logic             slow_tick,
  rand_req_sched_if.slave  bus,
  output sched_state_e     dbg_state
);

  sched_state_e            state_q, state_d;
  logic [2:0]              words_left_q, words_left_d;
  logic                    src_seed_q, src_seed_d;
  logic [OUTPUT_WIDTH-1:0] rand_byte_q, rand_byte_d;
  logic                    rand_valid_q, rand_valid_d;
  logic                    req_err_q, req_err_d;

  logic                    stage_push, stage_pop, stage_flush, stage_full;
  logic [OUTPUT_WIDTH-1:0] stage_dout;
  logic                    src_valid, fetch_en, timeout_hit;
  logic [OUTPUT_WIDTH-1:0] src_data;

  assign src_valid = src_seed_q ? bus.seed_valid : bus.drbg_valid;
  assign src_data  = src_seed_q ? bus.seed_data  : bus.drbg_data;

  // Ready only while the stage has room; PRESENT prefetches only if more words are owed.
  assign fetch_en   = !debug && !stage_full &&
                      ((state_q == FETCH) || ((state_q == PRESENT) && (words_left_q != 3'd0)));
  assign stage_push = fetch_en && src_valid;

  rand_req_sched_stage u_stage (
    .clk   (ic_clk),
    .rst_n (rst_n),
    .push  (stage_push),
    .pop   (stage_pop),
    .flush (stage_flush),
    .din   (src_data),
    .dout  (stage_dout),
    .full  (stage_full)
  );

`ifdef REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (fetch_en && !src_valid) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge ic_clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = fetch_en && !src_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    src_seed_d   = src_seed_q;
    rand_byte_d  = rand_byte_q;
    rand_valid_d = rand_valid_q;
    req_err_d    = 1'b0;
    stage_pop    = 1'b0;
    stage_flush  = 1'b0;
    if (debug) begin
      state_d      = IDLE;
      rand_valid_d = 1'b0;
      words_left_d = 3'd0;
      stage_flush  = 1'b1;
    end else if (timeout_hit) begin
      state_d      = IDLE;
      rand_valid_d = 1'b0;
      words_left_d = 3'd0;
      stage_flush  = 1'b1;
      req_err_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rand_req) begin
            if (req_valid(bus.rand_req_type)) begin
              words_left_d = req_words(bus.rand_req_type);
              src_seed_d   = req_is_seed(bus.rand_req_type);
              state_d      = FETCH;
            end else begin
              req_err_d = 1'b1;
            end
          end
        end
        FETCH: begin
          if (stage_full || stage_push) state_d = WAIT_TICK;
        end
        WAIT_TICK: begin
          if (slow_tick && stage_full) begin
            rand_byte_d  = stage_dout;
            rand_valid_d = 1'b1;
            words_left_d = (words_left_q != 3'd0) ? words_left_q - 3'd1 : 3'd0;
            stage_pop    = 1'b1;
            state_d      = PRESENT;
          end
        end
        PRESENT: begin
          if (slow_tick) begin
            if (words_left_q == 3'd0) begin
              rand_valid_d = 1'b0;
              state_d      = IDLE;
            end else if (stage_full) begin
              rand_byte_d  = stage_dout;
              words_left_d = words_left_q - 3'd1;
              stage_pop    = 1'b1;
            end else begin
              // A word landing on this same edge is issued from FETCH/WAIT_TICK next period.
              rand_valid_d = 1'b0;
              state_d      = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ic_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      words_left_q <= 3'd0;
      src_seed_q   <= 1'b0;
      rand_byte_q  <= '0;
      rand_valid_q <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      src_seed_q   <= src_seed_d;
      rand_byte_q  <= rand_byte_d;
      rand_valid_q <= rand_valid_d;
      req_err_q    <= req_err_d;
    end
  end

  assign bus.seed_ready = fetch_en && src_seed_q;
  assign bus.drbg_ready = fetch_en && !src_seed_q;
  assign bus.rand_byte  = rand_byte_q;
  assign bus.rand_valid = rand_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.req_err    = req_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rand_req_sched.sv
// Self-checking bench for rand_req_sched: queue-backed sources, word scoreboard, stability monitor.
module tb_rand_req_sched;
  import rand_req_sched_pkg::*;

  localparam int W        = OUTPUT_WIDTH;
  localparam int SLOW_DIV = 8;

  logic         ic_clk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         debug  = 1'b0;
  logic         slow_tick = 1'b0;
  sched_state_e dbg_state;

  rand_req_sched_if sif();

  rand_req_sched dut (
    .ic_clk    (ic_clk),
    .rst_n     (rst_n),
    .debug     (debug),
    .slow_tick (slow_tick),
    .bus       (sif),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seed_q[$];
  logic [W-1:0] drbg_q[$];
  bit           seed_en = 1'b1, drbg_en = 1'b1, rand_stall = 1'b0;

  int           n_words = 0, valid_falls = 0;
  bit           drbg_ready_seen = 1'b0;
  bit           prev_valid = 1'b0, last_tick = 1'b0;
  logic [W-1:0] prev_byte = '0;

  // ---------------- clock / reset / tick ----------------
  always #5 ic_clk = ~ic_clk;

  initial begin
    int tick_cnt;
    tick_cnt = 0;
    forever begin
      @(posedge ic_clk);
      #1;
      tick_cnt++;
      slow_tick = (tick_cnt % SLOW_DIV) == 0;
    end
  end

  // ---------------- source drivers ----------------
  initial begin
    bit s_hs, d_hs;
    sif.seed_valid = 1'b0; sif.seed_data = '0;
    sif.drbg_valid = 1'b0; sif.drbg_data = '0;
    forever begin
      @(negedge ic_clk);
      s_hs = sif.seed_valid && sif.seed_ready;
      d_hs = sif.drbg_valid && sif.drbg_ready;
      @(posedge ic_clk);
      #1;
      if (s_hs && seed_q.size() > 0) void'(seed_q.pop_front());
      if (d_hs && drbg_q.size() > 0) void'(drbg_q.pop_front());
      if (rand_stall) begin
        seed_en = 1'($urandom_range(0, 1));
        drbg_en = 1'($urandom_range(0, 1));
      end
      sif.seed_valid = seed_en && (seed_q.size() > 0);
      sif.seed_data  = (seed_q.size() > 0) ? seed_q[0] : '0;
      sif.drbg_valid = drbg_en && (drbg_q.size() > 0);
      sif.drbg_data  = (drbg_q.size() > 0) ? drbg_q[0] : '0;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge ic_clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_byte  = sif.rand_byte;
        last_tick  = slow_tick;
        continue;
      end
      if (sif.drbg_ready) drbg_ready_seen = 1'b1;
      if (sif.rand_valid && (!prev_valid || last_tick)) begin
        n_words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: rand_byte=%h issued, no word expected", sif.rand_byte);
        end else begin
          exp_w = exp_q.pop_front();
          if (sif.rand_byte !== exp_w) begin
            errors++;
            $display("FAIL word_value: rand_byte=%h expected %h", sif.rand_byte, exp_w);
          end
        end
      end else if (prev_valid && sif.rand_valid) begin
        checks++;
        if (sif.rand_byte !== prev_byte) begin
          errors++;
          $display("FAIL byte_stable: rand_byte=%h changed from %h without slow_tick", sif.rand_byte, prev_byte);
        end
      end
      if (prev_valid && !sif.rand_valid) valid_falls++;
      prev_valid = sif.rand_valid;
      prev_byte  = sif.rand_byte;
      last_tick  = slow_tick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input rand_req_t t);
    @(posedge ic_clk); #1;
    sif.rand_req      = 1'b1;
    sif.rand_req_type = t;
    @(posedge ic_clk); #1;
    sif.rand_req      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cnt;
    cnt = 0;
    while (sif.busy && cnt < budget) begin
      @(negedge ic_clk);
      cnt++;
    end
    if (sif.busy) begin
      errors++; checks++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, sif.busy, budget);
    end
  endtask

  task automatic wait_words(input string name, input int n, input int budget);
    int cnt;
    cnt = 0;
    while (n_words < n && cnt < budget) begin
      @(negedge ic_clk);
      cnt++;
    end
    if (n_words < n) begin
      errors++; checks++;
      $display("FAIL %s_word_timeout: words=%0d expected %0d", name, n_words, n);
    end
  endtask

  task automatic start_test();
    @(posedge ic_clk); #1;
    n_words = 0; valid_falls = 0; drbg_ready_seen = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge ic_clk);
    checks += 6;
    if (sif.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: %b expected 0", sif.busy); end
    if (sif.rand_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b expected 0", sif.rand_valid); end
    if (sif.rand_byte !== '0)    begin errors++; $display("FAIL reset_byte: %h expected 0", sif.rand_byte); end
    if (sif.seed_ready !== 1'b0 || sif.drbg_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: seed=%b drbg=%b expected 0/0", sif.seed_ready, sif.drbg_ready);
    end
    if (sif.req_err !== 1'b0)    begin errors++; $display("FAIL reset_err: %b expected 0", sif.req_err); end
    if (dbg_state !== IDLE)      begin errors++; $display("FAIL reset_state: %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_rdseed16();
    start_test();
    seed_q.push_back(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    drbg_q.push_back(16'h1234);
    issue_req(RDSEED_16);
    issue_req(RDRAND_16);
    wait_idle("rdseed16", 200);
    checks += 3;
    if (n_words != 1)         begin errors++; $display("FAIL rdseed16_count: words=%0d expected 1", n_words); end
    if (drbg_ready_seen)      begin errors++; $display("FAIL rdseed16_drbg_ready: seen=1 expected 0"); end
    if (drbg_q.size() != 1)   begin errors++; $display("FAIL rdseed16_ignored_req: drbg words left=%0d expected 1", drbg_q.size()); end
    drbg_q.delete();
  endtask

  task automatic test_back_to_back();
    start_test();
    for (int i = 1; i <= 4; i++) begin
      drbg_q.push_back(W'(i));
      exp_q.push_back(W'(i));
    end
    issue_req(RDRAND_64);
    wait_idle("b2b", 300);
    checks += 3;
    if (n_words != 4)      begin errors++; $display("FAIL b2b_count: words=%0d expected 4", n_words); end
    if (valid_falls != 1)  begin errors++; $display("FAIL b2b_gapless: valid_falls=%0d expected 1", valid_falls); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL b2b_state: %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_gap();
    start_test();
    seed_q.push_back(16'hA1A1);
    exp_q.push_back(16'hA1A1);
    exp_q.push_back(16'hA2A2);
    issue_req(RDSEED_32);
    wait_words("gap", 1, 100);
    repeat (3 * SLOW_DIV) @(negedge ic_clk);
    checks++;
    if (sif.rand_valid !== 1'b0) begin errors++; $display("FAIL gap_valid_drop: rand_valid=%b expected 0", sif.rand_valid); end
    @(posedge ic_clk); #1;
    seed_q.push_back(16'hA2A2);
    wait_idle("gap", 200);
    checks += 2;
    if (n_words != 2)     begin errors++; $display("FAIL gap_count: words=%0d expected 2", n_words); end
    if (valid_falls != 2) begin errors++; $display("FAIL gap_falls: valid_falls=%0d expected 2", valid_falls); end
  endtask

  task automatic test_random_stall();
    rand_req_t t;
    logic [W-1:0] w;
    int expected;
    start_test();
    rand_stall = 1'b1;
    expected = 0;
    for (int r = 0; r < 6; r++) begin
      t = rand_req_t'(3'($urandom_range(0, 5)));
      for (int k = 0; k < int'(req_words(t)); k++) begin
        w = W'($urandom_range(0, 65535));
        if (req_is_seed(t)) seed_q.push_back(w);
        else                drbg_q.push_back(w);
        exp_q.push_back(w);
        expected++;
      end
      issue_req(t);
      wait_idle("random", 600);
    end
    rand_stall = 1'b0; seed_en = 1'b1; drbg_en = 1'b1;
    checks += 2;
    if (n_words != expected) begin errors++; $display("FAIL random_count: words=%0d expected %0d", n_words, expected); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL random_drain: pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_debug();
    start_test();
    for (int i = 1; i <= 4; i++) drbg_q.push_back(W'(16'h0011 * i));
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    issue_req(RDRAND_64);
    wait_words("debug", 2, 200);
    @(posedge ic_clk); #1;
    debug = 1'b1;
    @(posedge ic_clk); #1;
    debug = 1'b0;
    checks += 2;
    if (sif.rand_valid !== 1'b0) begin errors++; $display("FAIL debug_valid: %b expected 0", sif.rand_valid); end
    if (sif.busy !== 1'b0)       begin errors++; $display("FAIL debug_busy: %b expected 0", sif.busy); end
    drbg_q.delete();
    repeat (5 * SLOW_DIV) @(negedge ic_clk);
    checks += 2;
    if (n_words != 2)      begin errors++; $display("FAIL debug_no_more: words=%0d expected 2", n_words); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL debug_pending: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    start_test();
    drbg_q.push_back(16'h0A0A);
    drbg_q.push_back(16'h0B0B);
    exp_q.push_back(16'h0A0A);
    issue_req(RDRAND_32);
    wait_words("rstmid", 1, 200);
    @(posedge ic_clk); #1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (sif.rand_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: %b expected 0", sif.rand_valid); end
    if (sif.busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: %b expected 0", sif.busy); end
    if (sif.rand_byte !== '0)    begin errors++; $display("FAIL rstmid_byte: %h expected 0", sif.rand_byte); end
    drbg_q.delete();
    @(posedge ic_clk); #1;
    rst_n = 1'b1;
    repeat (4 * SLOW_DIV) @(negedge ic_clk);
    checks += 2;
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL rstmid_resume: busy=%b expected 0", sif.busy); end
    if (n_words != 1)      begin errors++; $display("FAIL rstmid_count: words=%0d expected 1", n_words); end
  endtask

  task automatic test_bad_type();
    logic [2:0] bad [2];
    bad[0] = 3'b110;
    bad[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(posedge ic_clk); #1;
      sif.rand_req      = 1'b1;
      sif.rand_req_type = rand_req_t'(bad[i]);
      @(posedge ic_clk); #1;
      sif.rand_req      = 1'b0;
      checks += 2;
      if (sif.req_err !== 1'b1) begin errors++; $display("FAIL bad_type_err: req_err=%b expected 1 (type %b)", sif.req_err, bad[i]); end
      if (sif.busy !== 1'b0)    begin errors++; $display("FAIL bad_type_busy: busy=%b expected 0", sif.busy); end
      @(posedge ic_clk); #1;
      checks++;
      if (sif.req_err !== 1'b0) begin errors++; $display("FAIL bad_type_pulse: req_err=%b expected 0", sif.req_err); end
    end
  endtask

`ifdef REQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    start_test();
    issue_req(RDSEED_16);
    cnt = 0;
    while (sif.req_err !== 1'b1 && cnt < TIMEOUT_CYCLES + 20) begin
      @(negedge ic_clk);
      cnt++;
    end
    checks += 2;
    if (cnt < TIMEOUT_CYCLES || cnt > TIMEOUT_CYCLES + 2) begin
      errors++; $display("FAIL timeout_latency: req_err after %0d cycles expected ~%0d", cnt, TIMEOUT_CYCLES);
    end
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b expected 0", sif.busy); end
  endtask
`endif

  initial begin
    sif.rand_req      = 1'b0;
    sif.rand_req_type = RDSEED_16;
    repeat (3) @(posedge ic_clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_rdseed16();
    test_back_to_back();
    test_gap();
    test_random_stall();
    test_debug();
    test_reset_mid();
    test_bad_type();
`ifdef REQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: pending=%0d expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
